// File: rtl/router_pkg.sv
// router_pkg: shared types and helpers for the mesh router forwarding stages.
//
// Contents:
//   dir_e        destination of a decoded packet (ROUTE / NORTH / SOUTH)
//   PKT_W ...    default packet field layout and derived field widths
//   dir_decode() destination from the dx-nonzero flag and the dy sign bit
//   dx_step()    one hop along x: decrement (east) or increment (west), wrapping
//   sat_inc()    16-bit saturating increment used by the optional statistics
package router_pkg;

  localparam int PKT_W   = 30;
  localparam int DX_HI   = 29;
  localparam int DX_LO   = 21;
  localparam int DY_HI   = 20;
  localparam int DY_LO   = 12;
  localparam int DX_W    = DX_HI - DX_LO + 1;
  localparam int DY_W    = DY_HI - DY_LO + 1;
  localparam int STRIP_W = PKT_W - (DX_HI - DY_HI);

  typedef enum logic [1:0] {
    DIR_ROUTE = 2'd0,
    DIR_NORTH = 2'd1,
    DIR_SOUTH = 2'd2
  } dir_e;

  function automatic dir_e dir_decode(input logic dx_nonzero, input logic dy_sign);
    if (dx_nonzero) return DIR_ROUTE;
    return dy_sign ? DIR_SOUTH : DIR_NORTH;
  endfunction

  function automatic logic [DX_W-1:0] dx_step(input logic [DX_W-1:0] dx, input logic east);
    return east ? dx - DX_W'(1) : dx + DX_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/fifo_buffer.sv
// fifo_buffer: first-word-fall-through FIFO used for each forwarding output.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   wen, din   write request and data; ignored while full
//   ren        pop request; ignored while empty
//   dout       head entry, forced to 0 while empty
//   empty/full occupancy flags
module fifo_buffer #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  input  logic             ren,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_wr = wen && !full;
  assign w_do_rd = ren && !empty;
  assign dout    = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; stale contents are
  // never visible because dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: fair round-robin arbiter with a combinational one-hot grant.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointer returns to 0)
//   req[N]     request vector
//   advance    a grant was taken this cycle; pointer moves past the winner
//   grant[N]   one-hot (or zero) grant: first requester at or after the pointer
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_cand;
  logic             w_found;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant   = '0;
    w_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    if (w_found) grant[w_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (w_idx == PTR_W'(N - 1)) ? '0 : w_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/forward_ew_nway.sv
// forward_ew_nway: east/west forwarding stage merging NUM_SRC FWFT sources.
//
// Each source head is decoded: dx != 0 goes to the routing FIFO with dx moved one
// hop (EAST=1 decrements, EAST=0 increments); dx == 0 goes north (dy >= 0) or
// south (dy < 0) with the dx field stripped. A round-robin arbiter picks one
// source per cycle among those whose own destination FIFO has room.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   din, src_empty, src_ren     source heads / empty flags / pop strobes
//   ren_in_routing/north/south  downstream pops of the three output FIFOs
//   dout_routing/north/south    output FIFO heads (north/south are stripped)
//   *_buffer_empty              output FIFO empty flags
//   stat_*                      packet and stall counters, only when the
//                               FORWARD_EW_STATS_EN macro is defined
module forward_ew_nway
  import router_pkg::*;
#(
  parameter int PACKET_WIDTH = PKT_W,
  parameter int DX_MSB       = DX_HI,
  parameter int DX_LSB       = DX_LO,
  parameter int DY_MSB       = DY_HI,
  parameter int DY_LSB       = DY_LO,
  parameter int BUFFER_DEPTH = 4,
  parameter int NUM_SRC      = 3,
  parameter int EAST         = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_SRC*PACKET_WIDTH-1:0]        din,
  input  logic [NUM_SRC-1:0]                     src_empty,
  output logic [NUM_SRC-1:0]                     src_ren,
  input  logic                                   ren_in_routing,
  input  logic                                   ren_in_north,
  input  logic                                   ren_in_south,
  output logic [PACKET_WIDTH-1:0]                dout_routing,
  output logic [PACKET_WIDTH-(DX_MSB-DY_MSB)-1:0] dout_north,
  output logic [PACKET_WIDTH-(DX_MSB-DY_MSB)-1:0] dout_south,
  output logic                                   routing_buffer_empty,
  output logic                                   north_buffer_empty,
  output logic                                   south_buffer_empty
`ifdef FORWARD_EW_STATS_EN
  ,
  output logic [15:0]                            stat_pkts_route,
  output logic [15:0]                            stat_pkts_north,
  output logic [15:0]                            stat_pkts_south,
  output logic [15:0]                            stat_stall_cycles
`endif
);

  localparam int SW   = PACKET_WIDTH - (DX_MSB - DY_MSB);
  localparam int DROP = DX_MSB - DY_MSB;
  localparam logic [PACKET_WIDTH-1:0] LOW_MASK = PACKET_WIDTH'((64'd1 << (DY_MSB + 1)) - 64'd1);

  // The dx arithmetic comes from router_pkg, so the field layout must match it.
  if ((DX_MSB - DX_LSB + 1) != DX_W || (DY_MSB - DY_LSB + 1) != DY_W ||
      NUM_SRC < 2 || BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("forward_ew_nway: unsupported field layout or size parameters");
  end

  dir_e                    w_dir      [NUM_SRC];
  logic [PACKET_WIDTH-1:0] w_routed   [NUM_SRC];
  logic [SW-1:0]           w_stripped [NUM_SRC];
  logic [PACKET_WIDTH-1:0] w_head;
  logic [NUM_SRC-1:0]      w_req;
  logic [NUM_SRC-1:0]      w_grant;
  logic                    w_dest_full;
  logic                    w_full_route, w_full_north, w_full_south;
  logic                    w_wen_route, w_wen_north, w_wen_south;
  logic [PACKET_WIDTH-1:0] w_wdata_route;
  logic [SW-1:0]           w_wdata_north, w_wdata_south;

  // Per-source decode and request. Requests use this cycle's full flags, so a
  // same-cycle downstream pop never frees a slot early; reset masks all requests.
  always_comb begin
    w_head      = '0;
    w_dest_full = 1'b0;
    w_req       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_head   = din[i*PACKET_WIDTH +: PACKET_WIDTH];
      w_dir[i] = dir_decode(|w_head[DX_MSB:DX_LSB], w_head[DY_MSB]);
      w_routed[i] = w_head;
      w_routed[i][DX_MSB:DX_LSB] = dx_step(w_head[DX_MSB:DX_LSB], EAST != 0);
      // Keep bits at or below the dy MSB, pull the bits above dx down over it.
      w_stripped[i] = SW'((w_head & LOW_MASK) | ((w_head >> DROP) & ~LOW_MASK));
      case (w_dir[i])
        DIR_ROUTE: w_dest_full = w_full_route;
        DIR_NORTH: w_dest_full = w_full_north;
        DIR_SOUTH: w_dest_full = w_full_south;
        default:   w_dest_full = 1'b1;
      endcase
      w_req[i] = !rst && !src_empty[i] && !w_dest_full;
    end
  end

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (|w_grant),
    .grant   (w_grant)
  );

  assign src_ren = w_grant;

  // Steer the single granted packet to its destination FIFO.
  always_comb begin
    w_wen_route   = 1'b0;
    w_wen_north   = 1'b0;
    w_wen_south   = 1'b0;
    w_wdata_route = '0;
    w_wdata_north = '0;
    w_wdata_south = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        case (w_dir[i])
          DIR_ROUTE: begin w_wen_route = 1'b1; w_wdata_route = w_routed[i];   end
          DIR_NORTH: begin w_wen_north = 1'b1; w_wdata_north = w_stripped[i]; end
          DIR_SOUTH: begin w_wen_south = 1'b1; w_wdata_south = w_stripped[i]; end
          default:   ;
        endcase
      end
    end
  end

  fifo_buffer #(.WIDTH(PACKET_WIDTH), .DEPTH(BUFFER_DEPTH)) u_fifo_route (
    .clk (clk), .rst (rst), .wen (w_wen_route), .din (w_wdata_route),
    .ren (ren_in_routing), .dout (dout_routing),
    .empty (routing_buffer_empty), .full (w_full_route)
  );

  fifo_buffer #(.WIDTH(SW), .DEPTH(BUFFER_DEPTH)) u_fifo_north (
    .clk (clk), .rst (rst), .wen (w_wen_north), .din (w_wdata_north),
    .ren (ren_in_north), .dout (dout_north),
    .empty (north_buffer_empty), .full (w_full_north)
  );

  fifo_buffer #(.WIDTH(SW), .DEPTH(BUFFER_DEPTH)) u_fifo_south (
    .clk (clk), .rst (rst), .wen (w_wen_south), .din (w_wdata_south),
    .ren (ren_in_south), .dout (dout_south),
    .empty (south_buffer_empty), .full (w_full_south)
  );

`ifdef FORWARD_EW_STATS_EN
  logic w_stall;
  assign w_stall = (|(~src_empty)) && !(|w_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_route   <= '0;
      stat_pkts_north   <= '0;
      stat_pkts_south   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_pkts_route   <= sat_inc(stat_pkts_route,   w_wen_route);
      stat_pkts_north   <= sat_inc(stat_pkts_north,   w_wen_north);
      stat_pkts_south   <= sat_inc(stat_pkts_south,   w_wen_south);
      stat_stall_cycles <= sat_inc(stat_stall_cycles, w_stall);
    end
  end
`endif

endmodule
